// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds an external combinational full-adder cell one
// operand bit per clock (LSB first), carries between bits and assembles the result.
`timescale 1ns / 1ps

module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic [WIDTH-1:0] shift_nx;

    // NOTE: every signal gets its default first so no path through the case leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        // Written as shift-then-insert so WIDTH=1 needs no empty part-select.
        shift_nx = shift_q >> 1;
        shift_nx[WIDTH-1] = fa_sum;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_nx;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = shift_nx;
                    c_out_d = fa_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign fa_a   = busy & a_q[0];
    assign fa_b   = busy & b_q[0];
    assign fa_cin = busy & carry_q;
    assign sum    = sum_q;
    assign c_out  = c_out_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer that sits around the existing 1-bit full-adder cell.
- Latches two WIDTH-bit operands plus a carry-in, then presents them to the external full adder one bit per clock, LSB first.
- Holds the carry between bits and collects the sum bits returned by the cell.
- Drives the cell's inputs (upstream of it) and consumes its sum/carry outputs (downstream of it); produces a parallel WIDTH-bit result with a start/busy/done handshake.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE.
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
c_in  input  1  initial carry; captured on the accepted start.
fa_a  output  1  bit to full-adder input a.
fa_b  output  1  bit to full-adder input b.
fa_cin  output  1  carry to full-adder input c_in.
fa_sum  input  1  sum bit returned by the full adder (combinational, same cycle).
fa_cout  input  1  carry returned by the full adder (combinational, same cycle).
busy  output  1  high while in SHIFT.
done  output  1  single-cycle pulse; result valid.
sum  output  WIDTH  registered result.
c_out  output  1  registered final carry.

Behaviour:
- Reset: the single clock is clk; the asynchronous active-low reset is rst_n. While rst_n=0:
  - State goes to IDLE.
  - a_reg, b_reg, carry_reg, shift_reg, bit counter, sum and c_out are all 0.
  - busy=0 and done=0.
  - fa_a, fa_b and fa_cin are 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0; fa_a, fa_b and fa_cin are forced to 0.
  - start=1 at an edge: a_reg←a, b_reg←b, carry_reg←c_in, cnt←0; next state SHIFT.
- SHIFT:
  - busy=1.
  - fa_a=a_reg[0], fa_b=b_reg[0], fa_cin=carry_reg (combinational from registers).
  - Each edge:
    - shift_reg←{fa_sum, shift_reg[WIDTH-1:1]}.
    - a_reg and b_reg shift right by 1 with 0 fill.
    - carry_reg←fa_cout.
    - cnt←cnt+1.
  - At the edge where cnt=WIDTH-1:
    - sum←{fa_sum, shift_reg[WIDTH-1:1]}.
    - c_out←fa_cout.
    - Next state DONE.
  - The counter is sized to hold 0..WIDTH-1. WIDTH=1 gives exactly one SHIFT cycle.
- DONE:
  - done=1 and busy=0 for exactly one cycle; unconditional return to IDLE.
  - start is ignored in DONE; a new operation needs start in IDLE.
- Latency:
  - start is accepted at edge k.
  - SHIFT occupies the WIDTH cycles after that edge.
  - done is high during the cycle following edge k+WIDTH.
  - Issue rate is at most one operation per WIDTH+2 cycles.
- Results:
  - sum and c_out hold their value until the next operation completes. They do not change during SHIFT.
  - sum = (a + b + c_in) mod 2^WIDTH; c_out = bit WIDTH of that sum.
- start while busy or in DONE: no effect. Operands already captured are not disturbed, and a/b/c_in changes are ignored.
- Reset asserted mid-SHIFT aborts the operation immediately: all outputs return to 0, no done pulse, and the partial result is discarded.
- The full-adder cell is assumed combinational. fa_sum and fa_cout are sampled on the same edge that advances the shift.

Test Plan:
- WIDTH=4: a=4'd3, b=4'd5, c_in=0, start at edge 0 → busy high for 4 cycles; done pulse in the cycle after edge 4; sum=4'd8, c_out=0; fa_a sequence 1,1,0,0 and fa_b sequence 1,0,1,0.
- a=4'hF, b=4'h1, c_in=0 → sum=4'h0, c_out=1; fa_cin sequence 0,1,1,1.
- a=4'hF, b=4'hF, c_in=1 → sum=4'hF, c_out=1. Also a=0, b=0, c_in=1 → sum=4'h1, c_out=0.
- start held high continuously with operands changed during SHIFT → only one done per WIDTH+2 cycles; results match the operands captured at acceptance; sum unchanged until done.
- Drop rst_n for 1 ns in the second SHIFT cycle → busy, done, sum, c_out and fa_* go to 0 immediately with no done pulse; a following start with 2+2 gives sum=4, c_out=0.
- Exhaustive check with WIDTH=1 and WIDTH=4 over all a, b and c_in against a behavioural model; fa_* must be 0 in every IDLE and DONE cycle.
